// File: rtl/cipher_iter.sv
// Iterative AES encryption core: one round per clock, on-the-fly key expansion
// over an NK-word sliding window; AES-128/192/256 selected by NK.
module cipher_iter #(
    parameter int NB = 4,
    parameter int NK = 4,
    parameter int NR = NK + 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic [32*NK-1:0] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             busy
);

    if (NB != 4) begin : g_bad_nb
        $error("cipher_iter: NB must be 4");
    end
    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("cipher_iter: NK must be 4, 6 or 8");
    end
    if (NR != NK + 6) begin : g_bad_nr
        $error("cipher_iter: NR must equal NK+6");
    end

    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xt2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] xt3(input logic [7:0] b);
        return xt2(b) ^ b;
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    state_t       state;
    logic [127:0] st;
    word_t        win [NK];
    logic [3:0]   ph;
    logic [7:0]   rcon;
    logic [3:0]   rnd;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never waits on ready, and data holds until the transfer.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == ROUND);
    assign out_data  = st;

    // Key window holds w[b..b+NK-1]; each round appends four words and the
    // round key is words 4..7 of (window ++ new words).
    word_t      sub_src;
    word_t      t_word;
    logic [1:0] sub_pos;
    logic       sub_act;
    logic       rot;
    word_t      n    [4];
    word_t      ext  [NK+4];
    word_t      rk   [4];
    word_t      nxt_win [NK];
    logic [4:0] ph_sum;
    logic [3:0] ph_nxt;

    if (NK == 6) begin : g_sel6
        // With six-word windows the Rcon word lands on slot 0 or slot 2 of the
        // four new words; slot 2 needs w[i-1] rebuilt from plain XORs.
        assign sub_src = (ph == 4'd4) ? (win[1] ^ win[0] ^ win[5]) : win[5];
        assign sub_pos = (ph == 4'd4) ? 2'd2 : 2'd0;
        assign sub_act = (ph != 4'd2);
        assign rot     = 1'b1;
    end else begin : g_sel48
        assign sub_src = win[NK-1];
        assign sub_pos = 2'd0;
        assign sub_act = 1'b1;
        assign rot     = (NK == 4) || (ph == 4'd0);
    end

    always_comb begin
        t_word = rot ? (sub_word({sub_src[23:0], sub_src[31:24]}) ^ {rcon, 24'h0})
                     : sub_word(sub_src);
        n[0] = win[0] ^ ((sub_act && sub_pos == 2'd0) ? t_word : win[NK-1]);
        for (int j = 1; j < 4; j++) begin
            n[j] = win[j] ^ ((sub_act && sub_pos == 2'(j)) ? t_word : n[j-1]);
        end
        for (int k = 0; k < NK; k++) ext[k] = win[k];
        for (int j = 0; j < 4; j++) ext[NK+j] = n[j];
        for (int j = 0; j < 4; j++) rk[j] = ext[4+j];
        for (int k = 0; k < NK; k++) nxt_win[k] = ext[4+k];
        ph_sum = {1'b0, ph} + 5'd4;
        ph_nxt = (ph_sum >= 5'(NK)) ? 4'(ph_sum - 5'(NK)) : ph_sum[3:0];
    end

    logic [7:0]   sb_b [16];
    logic [7:0]   sr_b [16];
    logic [7:0]   mc_b [16];
    logic [127:0] round_out;
    logic         last_round;

    assign last_round = (rnd == 4'(NR));

    always_comb begin
        round_out = '0;
        for (int k = 0; k < 16; k++) sb_b[k] = SBOX[st[127-8*k -: 8]];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_b[4*c+r] = sb_b[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc_b[4*c]   = xt2(sr_b[4*c]) ^ xt3(sr_b[4*c+1]) ^ sr_b[4*c+2] ^ sr_b[4*c+3];
            mc_b[4*c+1] = sr_b[4*c] ^ xt2(sr_b[4*c+1]) ^ xt3(sr_b[4*c+2]) ^ sr_b[4*c+3];
            mc_b[4*c+2] = sr_b[4*c] ^ sr_b[4*c+1] ^ xt2(sr_b[4*c+2]) ^ xt3(sr_b[4*c+3]);
            mc_b[4*c+3] = xt3(sr_b[4*c]) ^ sr_b[4*c+1] ^ sr_b[4*c+2] ^ xt2(sr_b[4*c+3]);
        end
        for (int k = 0; k < 16; k++) begin
            round_out[127-8*k -: 8] = (last_round ? sr_b[k] : mc_b[k]) ^ rk[k/4][31-8*(k%4) -: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            st    <= '0;
            for (int k = 0; k < NK; k++) win[k] <= '0;
            ph    <= '0;
            rcon  <= '0;
            rnd   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st <= in_data ^ in_key[32*NK-1 -: 128];
                        for (int k = 0; k < NK; k++) win[k] <= in_key[32*NK-1-32*k -: 32];
                        ph    <= '0;
                        rcon  <= 8'h01;
                        rnd   <= 4'd1;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    st  <= round_out;
                    for (int k = 0; k < NK; k++) win[k] <= nxt_win[k];
                    ph  <= ph_nxt;
                    if (sub_act && rot) rcon <= xt2(rcon);
                    rnd <= rnd + 4'd1;
                    if (last_round) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_iter.sv
// Bench for cipher_iter: NK=4/6/8 instances, FIPS-197 vectors, handshake corners
// and random blocks checked against a textbook AES model.
module tb_cipher_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   iv;
  logic [127:0] in_data;
  logic [255:0] key_bus;
  logic         out_ready;
  logic [2:0]   ir, ov, bs;
  logic [127:0] od [3];

  always #5 clk = ~clk;

  cipher_iter #(.NK(4)) u_nk4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data),
    .in_key(key_bus[255:128]), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bs[0]));
  cipher_iter #(.NK(6)) u_nk6 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data),
    .in_key(key_bus[255:64]), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bs[1]));
  cipher_iter #(.NK(8)) u_nk8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data),
    .in_key(key_bus), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .busy(bs[2]));

  int total = 0;
  int bad = 0;
  logic [127:0] exp_q [$];
  logic [7:0] sb [256];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] x, int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [127:0] aes_ref(logic [255:0] key, int nk, logic [127:0] pt);
    logic [31:0]  w [60];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c+row] = sb[s[4*((c+row)%4)+row]];
      for (int c = 0; c < 4; c++) begin
        if (r < nr) begin
          s[4*c]   = gm(t[4*c], 2) ^ gm(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 2) ^ gm(t[4*c+2], 3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 2) ^ gm(t[4*c+3], 3);
          s[4*c+3] = gm(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 2);
        end else begin
          for (int row = 0; row < 4; row++) s[4*c+row] = t[4*c+row];
        end
        for (int row = 0; row < 4; row++) s[4*c+row] ^= w[4*r+c][31-8*row -: 8];
      end
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  // ---------------- check / driver tasks ----------------
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [127:0] pt, input logic [255:0] key);
    int n = 0;
    while (!ir[d] && n < 50) begin
      tick();
      n++;
    end
    chk("send_ready", ir[d], 1'b1);
    in_data = pt;
    key_bus = key;
    iv[d] = 1'b1;
    tick();
    iv[d] = 1'b0;
  endtask

  task automatic recv(input int d, input int hold, output int lat);
    logic [127:0] e;
    lat = 0;
    while (!ov[d] && lat < 40) begin
      tick();
      lat++;
    end
    chk("out_valid_rise", ov[d], 1'b1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1'b0, 1'b1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      chk("hold_data", od[d], e);
      chk("hold_in_ready", ir[d], 1'b0);
      chk("hold_valid", ov[d], 1'b1);
      tick();
    end
    chk("out_data", od[d], e);
    chk("hs_in_ready", ir[d], 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_after_hs", {ov[d], ir[d]}, 2'b01);
  endtask

  typedef struct {
    int           d;
    logic [127:0] pt;
    logic [255:0] key;
    logic [127:0] exp;
  } vec_t;

  vec_t         tbl [4];
  int           lat, cyc, acc_c, hs_c, got, blk;
  bit           acc, hs, saw_valid;
  logic [127:0] rpt;
  logic [255:0] rkey;

  initial begin
    rst_n = 1'b0;
    iv = '0;
    in_data = '0;
    key_bus = '0;
    out_ready = 1'b0;
    build_sbox();

    tbl[0] = '{0, 128'h3243f6a8885a308d313198a2e0370734,
               {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 128'h3925841d02dc09fbdc118597196a0b32};
    tbl[1] = '{0, 128'h00112233445566778899aabbccddeeff,
               {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    tbl[2] = '{1, 128'h00112233445566778899aabbccddeeff,
               {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
               128'hdda97ca4864cdfe06eaf70a0ec0d7191};
    tbl[3] = '{2, 128'h00112233445566778899aabbccddeeff,
               256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
               128'h8ea2b7ca516745bfeafc49904b496089};

    // clock/reset
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      chk("rst_in_ready", ir[d], 1'b1);
      chk("rst_out_valid", ov[d], 1'b0);
      chk("rst_busy", bs[d], 1'b0);
      chk("rst_out_data", od[d], 128'h0);
    end
    rst_n = 1'b1;
    tick();

    // known-answer vectors and latency
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(tbl[i].exp);
      send(tbl[i].d, tbl[i].pt, tbl[i].key);
      chk("busy_in_round", bs[tbl[i].d], 1'b1);
      recv(tbl[i].d, 0, lat);
      chk("latency", lat, 10 + 2*tbl[i].d);
    end

    // backpressure, then T1/T2 back to back
    exp_q.push_back(tbl[0].exp);
    send(0, tbl[0].pt, tbl[0].key);
    recv(0, 5, lat);
    for (int i = 0; i < 2; i++) exp_q.push_back(tbl[i].exp);
    send(0, tbl[0].pt, tbl[0].key);
    recv(0, 0, lat);
    send(0, tbl[1].pt, tbl[1].key);
    recv(0, 0, lat);

    // streaming with in_valid and out_ready held high
    out_ready = 1'b1;
    blk = 0; cyc = 0; acc_c = 0; hs_c = -1; got = 0;
    rpt = {$urandom, $urandom, $urandom, $urandom};
    rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    in_data = rpt;
    key_bus = rkey;
    exp_q.push_back(aes_ref(rkey, 4, rpt));
    iv[0] = 1'b1;
    while (got < 3 && cyc < 200) begin
      acc = iv[0] && ir[0];
      hs = ov[0];
      if (acc) begin
        if (hs_c >= 0) chk("hs_to_next_accept", cyc - hs_c, 1);
        acc_c = cyc;
      end
      if (hs) begin
        chk("accept_to_hs", cyc - acc_c, 11);
        chk("stream_data", od[0], (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx);
        hs_c = cyc;
        got++;
      end
      tick();
      cyc++;
      if (acc) begin
        blk++;
        if (blk < 3) begin
          rpt = {$urandom, $urandom, $urandom, $urandom};
          rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
          in_data = rpt;
          key_bus = rkey;
          exp_q.push_back(aes_ref(rkey, 4, rpt));
        end else begin
          iv[0] = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    iv[0] = 1'b0;
    chk("stream_count", got, 3);
    exp_q.delete();

    // reset in the middle of round 5
    send(0, tbl[0].pt, tbl[0].key);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", ir[0], 1'b1);
    chk("abort_out_valid", ov[0], 1'b0);
    chk("abort_busy", bs[0], 1'b0);
    chk("abort_out_data", od[0], 128'h0);
    tick();
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (ov[0]) saw_valid = 1'b1;
      tick();
    end
    chk("no_valid_after_abort", saw_valid, 1'b0);

    // input changes and in_valid during ROUND are ignored
    exp_q.push_back(tbl[0].exp);
    send(0, tbl[0].pt, tbl[0].key);
    for (int i = 0; i < 5; i++) begin
      iv[0] = 1'b1;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      key_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
    end
    iv[0] = 1'b0;
    recv(0, 0, lat);
    exp_q.push_back(tbl[1].exp);
    send(0, tbl[1].pt, tbl[1].key);
    recv(0, 0, lat);

    // random blocks against the model, random backpressure
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 6; i++) begin
        rpt = {$urandom, $urandom, $urandom, $urandom};
        rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        exp_q.push_back(aes_ref(rkey, 4 + 2*d, rpt));
        send(d, rpt, rkey);
        recv(d, $urandom_range(0, 3), lat);
        chk("rand_latency", lat, 10 + 2*d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
